// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: default datapath width,
// the canonical NOP and the {pc, instr} stage bundle.
package pipeline_pkg;

  localparam int DEF_XLEN = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [DEF_XLEN-1:0] pc;
    logic [DEF_XLEN-1:0] instr;
  } pipe_t;

endpackage

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: first-word fall-through
// FIFO of {pc, instr} with flush and occupancy count.
module if_id_queue
  import pipeline_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [XLEN-1:0]            in_instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_pc_plus4,
  output logic [XLEN-1:0]            out_instr,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [XLEN-1:0] pc_q    [DEPTH];
  logic [XLEN-1:0] instr_q [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [XLEN-1:0]  last_pc;
  logic             push;
  logic             pop;

  // Handshake qualification; flush suppresses both sides.
  always_comb begin
    in_ready  = (count != FULL);
    out_valid = vld[rd_ptr];
    push      = in_valid && in_ready && !flush;
    pop       = out_valid && out_ready && !flush;
  end

  // Head presentation; pc holds its last value while empty.
  always_comb begin
    out_pc       = out_valid ? pc_q[rd_ptr] : last_pc;
    out_pc_plus4 = out_pc + XLEN'(4);
    out_instr    = out_valid ? instr_q[rd_ptr] : XLEN'(NOP_INSTR);
  end

  // Entry storage; contents need no reset, validity is tracked apart.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr]    <= in_pc;
      instr_q[wr_ptr] <= in_instr;
    end
  end

  // Pointers, occupancy, valid bits and held head pc.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      vld     <= '0;
      last_pc <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      vld    <= '0;
      if (out_valid) last_pc <= pc_q[rd_ptr];
    end else begin
      if (out_valid) last_pc <= pc_q[rd_ptr];
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + PW'(1);
      end
      if (push) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
